// File: rtl/cgra_cfg_sequencer.sv
// ============================================================================
// Module   : cgra_cfg_sequencer
// Purpose  : Context-memory sequencer streaming a looped frame range to one PE.
//            Optional macro CGRA_CFG_SEQ_STATS_EN adds the issued_count port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cgra_cfg_sequencer #(
    parameter int DEPTH       = 16,
    parameter int PTR_WIDTH   = 4,
    parameter int FRAME_WIDTH = 64,
    parameter int LOOP_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_valid,
    input  logic [PTR_WIDTH-1:0]   ld_addr,
    input  logic [FRAME_WIDTH-1:0] ld_frame,
    output logic                   ld_ready,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PTR_WIDTH-1:0]   base_addr,
    input  logic [PTR_WIDTH-1:0]   end_addr,
    input  logic [LOOP_WIDTH-1:0]  loop_count,
    output logic [FRAME_WIDTH-1:0] config_frame,
    output logic                   config_valid,
    input  logic                   pe_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
`ifdef CGRA_CFG_SEQ_STATS_EN
    output logic [31:0]            issued_count,
`endif
    output logic [LOOP_WIDTH-1:0]  iter_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [FRAME_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]   r_pc;
    logic [PTR_WIDTH-1:0]   r_base;
    logic [PTR_WIDTH-1:0]   r_end;
    logic [LOOP_WIDTH-1:0]  r_loop;
    logic [LOOP_WIDTH-1:0]  r_iter;
    logic [FRAME_WIDTH-1:0] r_frame;
    logic                   r_err;

    logic                   w_idle;
    logic                   w_xfer;
    logic                   w_at_end;
    logic                   w_final_pass;
    logic                   w_start_ok;
    logic                   w_start_bad;
    logic [PTR_WIDTH-1:0]   w_pc_inc;
    logic [FRAME_WIDTH-1:0] w_first;

    assign w_idle       = (r_state == S_IDLE);
    assign w_xfer       = (r_state == S_RUN) && pe_ready;
    assign w_at_end     = (r_pc == r_end);
    assign w_final_pass = (r_loop != '0) && (r_iter == r_loop - LOOP_WIDTH'(1));
    assign w_start_ok   = w_idle && start && !abort && (end_addr >= base_addr);
    assign w_start_bad  = w_idle && start && !abort && (end_addr < base_addr);
    assign w_pc_inc     = r_pc + PTR_WIDTH'(1);

    // A write landing on the base slot in the start cycle must be seen by the first frame.
    assign w_first = (ld_valid && (ld_addr == base_addr)) ? ld_frame : r_mem[base_addr];

    // Context memory intentionally has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (ld_valid && ld_ready) begin
            r_mem[ld_addr] <= ld_frame;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok) w_state_nxt = S_RUN;
            S_RUN:  if (w_xfer && w_at_end && w_final_pass) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= '0;
            r_base  <= '0;
            r_end   <= '0;
            r_loop  <= '0;
            r_iter  <= '0;
            r_frame <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_start_bad;
            if (w_start_ok) begin
                r_pc    <= base_addr;
                r_base  <= base_addr;
                r_end   <= end_addr;
                r_loop  <= loop_count;
                r_iter  <= '0;
                r_frame <= w_first;
            end else if (w_xfer) begin
                if (!w_at_end) begin
                    r_pc    <= w_pc_inc;
                    r_frame <= r_mem[w_pc_inc];
                end else if (!w_final_pass) begin
                    // Wrap straight back to base so the loop has no bubble.
                    r_pc    <= r_base;
                    r_iter  <= r_iter + LOOP_WIDTH'(1);
                    r_frame <= r_mem[r_base];
                end
            end
        end
    end

`ifdef CGRA_CFG_SEQ_STATS_EN
    logic [31:0] r_issued;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issued <= '0;
        end else if (w_start_ok) begin
            r_issued <= '0;
        end else if (w_xfer && (r_issued != 32'hFFFF_FFFF)) begin
            r_issued <= r_issued + 32'd1;
        end
    end

    assign issued_count = r_issued;
`endif

    assign ld_ready     = w_idle;
    assign config_valid = (r_state == S_RUN);
    assign busy         = (r_state == S_RUN);
    assign done         = (r_state == S_DONE);
    assign err          = r_err;
    assign config_frame = r_frame;
    assign iter_idx     = r_iter;

endmodule

`default_nettype wire

// File: tb/tb_cgra_cfg_sequencer.sv
// ============================================================================
// Module   : tb_cgra_cfg_sequencer
// Purpose  : Scoreboard bench for cgra_cfg_sequencer (directed scenarios).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cgra_cfg_sequencer;

    logic        clk;
    logic        rst;
    logic        ld_valid;
    logic [3:0]  ld_addr;
    logic [63:0] ld_frame;
    logic        ld_ready;
    logic        start;
    logic        abort;
    logic [3:0]  base_addr;
    logic [3:0]  end_addr;
    logic [15:0] loop_count;
    logic [63:0] config_frame;
    logic        config_valid;
    logic        pe_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] iter_idx;
`ifdef CGRA_CFG_SEQ_STATS_EN
    logic [31:0] issued_count;
`endif

    cgra_cfg_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_frame     (ld_frame),
        .ld_ready     (ld_ready),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .end_addr     (end_addr),
        .loop_count   (loop_count),
        .config_frame (config_frame),
        .config_valid (config_valid),
        .pe_ready     (pe_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
`ifdef CGRA_CFG_SEQ_STATS_EN
        .issued_count (issued_count),
`endif
        .iter_idx     (iter_idx)
    );

    typedef struct packed {
        logic [63:0] f;
        logic [15:0] it;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_xfer = 0;
    int   n_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted frame is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) n_done++;
            if (config_valid && pe_ready) begin
                n_xfer++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got frame 0x%0h with nothing expected", config_frame);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_frame", config_frame, e.f);
                    check("sb_iter", {48'd0, iter_idx}, {48'd0, e.it});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [63:0] f);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_frame = f;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic start_seq(input logic [3:0] b, input logic [3:0] e, input logic [15:0] l);
        base_addr  = b;
        end_addr   = e;
        loop_count = l;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
        end
    endtask

    task automatic push_abc();
        for (int p = 0; p < 2; p++) begin
            sb_q.push_back('{f: 64'hA, it: 16'(p)});
            sb_q.push_back('{f: 64'hB, it: 16'(p)});
            sb_q.push_back('{f: 64'hC, it: 16'(p)});
        end
    endtask

    int n;
    int x0;
    int d0;

    initial begin
        rst = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_frame = '0; start = 1'b0;
        abort = 1'b0; base_addr = '0; end_addr = '0; loop_count = '0; pe_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_valid", {63'd0, config_valid}, 64'd0);
        check("rst_frame", config_frame, 64'd0);
        check("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
        check("rst_busy_done_err", {61'd0, busy, done, err}, 64'd0);
        check("rst_iter", {48'd0, iter_idx}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic loop
        load(4'd2, 64'hA); load(4'd3, 64'hB); load(4'd4, 64'hC);
        push_abc();
        x0 = n_xfer;
        start_seq(4'd2, 4'd4, 16'd2);
        check("start_valid", {63'd0, config_valid}, 64'd1);
        check("start_frame", config_frame, 64'hA);
        check("run_busy", {63'd0, busy}, 64'd1);
        check("run_ld_ready", {63'd0, ld_ready}, 64'd0);
        wait_done(20, n);
        check("done_latency", 64'(n), 64'd6);
        check("done_valid_low", {63'd0, config_valid}, 64'd0);
        check("basic_xfers", 64'(n_xfer - x0), 64'd6);
`ifdef CGRA_CFG_SEQ_STATS_EN
        check("stats_basic", {32'd0, issued_count}, 64'd6);
`endif
        tick();
        check("idle_ld_ready", {63'd0, ld_ready}, 64'd1);
        check("done_one_cycle", {63'd0, done}, 64'd0);

        // Backpressure on the second frame
        push_abc();
        x0 = n_xfer;
        start_seq(4'd2, 4'd4, 16'd2);
        tick();
        pe_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_frame_hold", config_frame, 64'hB);
            check("bp_valid_hold", {63'd0, config_valid}, 64'd1);
        end
        pe_ready = 1'b1;
        wait_done(20, n);
        tick();
        check("bp_xfers", 64'(n_xfer - x0), 64'd6);

        // Illegal range
        start_seq(4'd5, 4'd3, 16'd1);
        check("illegal_err", {63'd0, err}, 64'd1);
        check("illegal_busy_valid", {62'd0, busy, config_valid}, 64'd0);
        tick();
        check("illegal_err_pulse", {63'd0, err}, 64'd0);
        check("illegal_idle", {63'd0, ld_ready}, 64'd1);

        // Same-cycle bypass, single-slot range
        sb_q.push_back('{f: 64'h1234, it: 16'd0});
        ld_valid = 1'b1; ld_addr = 4'd0; ld_frame = 64'h1234;
        start_seq(4'd0, 4'd0, 16'd1);
        ld_valid = 1'b0;
        check("bypass_frame", config_frame, 64'h1234);
        wait_done(10, n);
        tick();

        // Load attempted while running is dropped
        sb_q.push_back('{f: 64'h1234, it: 16'd0});
        start_seq(4'd0, 4'd0, 16'd1);
        ld_valid = 1'b1; ld_addr = 4'd0; ld_frame = 64'hDEAD;
        wait_done(10, n);
        ld_valid = 1'b0;
        tick();
        sb_q.push_back('{f: 64'h1234, it: 16'd0});
        start_seq(4'd0, 4'd0, 16'd1);
        wait_done(10, n);
        tick();

        // Infinite loop then abort
        load(4'd5, 64'h50); load(4'd6, 64'h60); load(4'd7, 64'h70);
        for (int p = 0; p < 10; p++) begin
            sb_q.push_back('{f: 64'h50, it: 16'(p)});
            sb_q.push_back('{f: 64'h60, it: 16'(p)});
            sb_q.push_back('{f: 64'h70, it: 16'(p)});
        end
        sb_q.push_back('{f: 64'h50, it: 16'd10});
        d0 = n_done;
        start_seq(4'd5, 4'd7, 16'd0);
        for (int i = 0; i < 30; i++) tick();
        check("inf_iter10", {48'd0, iter_idx}, 64'd10);
        check("inf_still_valid", {63'd0, config_valid}, 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", {63'd0, config_valid}, 64'd0);
        check("abort_idle", {61'd0, busy, done, ld_ready}, 64'd1);
        for (int i = 0; i < 3; i++) tick();
        check("abort_no_done", 64'(n_done - d0), 64'd0);
        sb_q.push_back('{f: 64'h50, it: 16'd0});
        sb_q.push_back('{f: 64'h60, it: 16'd0});
        start_seq(4'd5, 4'd6, 16'd1);
        wait_done(10, n);
        check("after_abort_len", 64'(n), 64'd2);
        tick();

        // Reset during the second frame
        sb_q.push_back('{f: 64'hA, it: 16'd0});
        start_seq(4'd2, 4'd4, 16'd2);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {60'd0, config_valid, busy, done, err}, 64'd0);
        check("mid_rst_frame", config_frame, 64'd0);
        check("mid_rst_iter", {48'd0, iter_idx}, 64'd0);
`ifdef CGRA_CFG_SEQ_STATS_EN
        check("stats_rst", {32'd0, issued_count}, 64'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        push_abc();
        x0 = n_xfer;
        start_seq(4'd2, 4'd4, 16'd2);
        wait_done(20, n);
        check("replay_xfers", 64'(n_xfer - x0), 64'd6);
`ifdef CGRA_CFG_SEQ_STATS_EN
        check("stats_replay", {32'd0, issued_count}, 64'd6);
`endif
        tick();
        tick();
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1);
    end

endmodule

`default_nettype wire
